inst_fetch_unit: RTL and testbench

- Sequential front end of the single-cycle MIPS-style CPU. Owns the PC register and runs a req/ack fetch handshake with instruction memory.
- Presents pc_cnt and the fetched instruction to decode/execute, then commits the execute stage's pc_return as the next PC.
- Tolerates variable-latency instruction memory. Detects misaligned-PC and fetch-timeout faults.

---
 rtl/cpu_pkg.sv | 24 ++
 rtl/fetch_timeout_cnt.sv | 31 +++
 rtl/inst_fetch_unit.sv | 88 ++++++++
 tb/tb_inst_fetch_unit.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the MIPS-style CPU front end.
// Fetch FSM states, fault codes and PC helpers.
package cpu_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_EXEC   = 3'd2,
        S_HALTED = 3'd3,
        S_ERR    = 3'd4
    } state_e;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ALIGN   = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    localparam logic [31:0] INST_NOP = 32'h0000_0000;
    localparam logic [31:0] PC_STEP  = 32'd4;

    function automatic logic pc_aligned(input logic [31:0] pc);
        return pc[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/fetch_timeout_cnt.sv
// Clear/enable wait counter for the fetch handshake.
// tc flags the enabled cycle whose increment would reach TIMEOUT.
module fetch_timeout_cnt
    import cpu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [15:0] LAST = 16'(TIMEOUT - 1);

    logic [15:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 16'd0;
        end else if (clr) begin
            count <= 16'd0;
        end else if (en) begin
            count <= count + 16'd1;
        end
    end

    assign tc = en && (count == LAST);

endmodule

// File: rtl/inst_fetch_unit.sv
// PC register and req/ack instruction fetch FSM.
// Commits pc_return after a one-cycle EXEC; traps misaligned PC and timeouts.
module inst_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_return,
    input  logic        halt,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic [31:0] pc_cnt,
    output logic [31:0] inst,
    output logic        inst_valid,
    output logic [31:0] retire_cnt,
    output logic        fetch_err,
    output logic [1:0]  err_code
);

    state_e state;
    logic   fetching;
    logic   acked;
    logic   tmo_tc;

    assign fetching  = (state == S_FETCH);
    assign acked     = fetching && imem_ack;
    assign imem_req  = fetching;
    assign imem_addr = pc_cnt;

    fetch_timeout_cnt #(
        .TIMEOUT(TIMEOUT)
    ) u_tmo (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (acked),
        .en   (fetching && !imem_ack),
        .tc   (tmo_tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            pc_cnt     <= RESET_PC;
            inst       <= INST_NOP;
            inst_valid <= 1'b0;
            retire_cnt <= 32'd0;
            fetch_err  <= 1'b0;
            err_code   <= ERR_NONE;
        end else begin
            inst_valid <= 1'b0;
            unique case (state)
                S_IDLE: state <= S_FETCH;
                S_FETCH: begin
                    if (imem_ack) begin
                        inst       <= imem_rdata;
                        inst_valid <= 1'b1;
                        state      <= S_EXEC;
                    end else if (tmo_tc) begin
                        fetch_err <= 1'b1;
                        err_code  <= ERR_TIMEOUT;
                        state     <= S_ERR;
                    end
                end
                S_EXEC: begin
                    retire_cnt <= retire_cnt + 32'd1;
                    // A bad target keeps the old PC so the faulting branch is visible.
                    if (!pc_aligned(pc_return)) begin
                        fetch_err <= 1'b1;
                        err_code  <= ERR_ALIGN;
                        state     <= S_ERR;
                    end else begin
                        pc_cnt <= pc_return;
                        state  <= halt ? S_HALTED : S_FETCH;
                    end
                end
                S_HALTED: if (!halt) state <= S_FETCH;
                S_ERR:    state <= S_ERR;
                default:  state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit.
// Table vectors, hand sequences and random transactions vs a PC/retire model.
module tb_inst_fetch_unit;
    import cpu_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0040;
    localparam int unsigned TMO    = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pc_return = 32'h0;
    logic        halt = 1'b0;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] pc_cnt;
    logic [31:0] inst;
    logic        inst_valid;
    logic [31:0] retire_cnt;
    logic        fetch_err;
    logic [1:0]  err_code;

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_retire = 0;
    logic [31:0] cur_pc;

    inst_fetch_unit #(
        .RESET_PC(RST_PC),
        .TIMEOUT (TMO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pc_return (pc_return),
        .halt      (halt),
        .imem_ack  (imem_ack),
        .imem_rdata(imem_rdata),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .pc_cnt    (pc_cnt),
        .inst      (inst),
        .inst_valid(inst_valid),
        .retire_cnt(retire_cnt),
        .fetch_err (fetch_err),
        .err_code  (err_code)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          wait_c;
        logic [31:0] rdata;
        logic [31:0] pcr;
        logic        hlt;
        int          hold;
        logic [31:0] exp_addr;
        logic [31:0] exp_inst;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_req", 32'(imem_req), 0);
        chk("rst_pc", pc_cnt, RST_PC);
        chk("rst_inst", inst, INST_NOP);
        chk("rst_valid", 32'(inst_valid), 0);
        chk("rst_retire", retire_cnt, 0);
        chk("rst_err", 32'(fetch_err), 0);
        chk("rst_code", 32'(err_code), 32'(ERR_NONE));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        exp_retire = 0;
        cur_pc = RST_PC;
    endtask

    task automatic wait_req();
        int n = 0;
        while (!imem_req && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("req_up", 32'(imem_req), 1);
    endtask

    // One instruction: waits wait_c cycles before ack, then commits pcr.
    task automatic fetch_one(input int wait_c, input logic [31:0] rd,
                             input logic [31:0] pcr, input logic hlt,
                             input int hold, input logic [31:0] exp_addr,
                             input logic [31:0] exp_inst);
        wait_req();
        chk("addr", imem_addr, exp_addr);
        for (int i = 0; i < wait_c; i++) begin
            imem_ack = 1'b0;
            imem_rdata = $urandom();
            halt = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("req_hold", 32'(imem_req), 1);
            chk("addr_hold", imem_addr, exp_addr);
            chk("valid_wait", 32'(inst_valid), 0);
        end
        imem_ack = 1'b1;
        imem_rdata = rd;
        pc_return = pcr;
        halt = hlt;
        @(negedge clk);
        chk("valid", 32'(inst_valid), 1);
        chk("inst", inst, exp_inst);
        chk("pc_exec", pc_cnt, exp_addr);
        chk("req_exec", 32'(imem_req), 0);
        imem_ack = 1'b0;
        imem_rdata = $urandom();
        exp_retire++;
        @(negedge clk);
        pc_return = $urandom();
        chk("retire", retire_cnt, exp_retire);
        chk("no_err", 32'(fetch_err), 0);
        chk("pc_next", pc_cnt, pcr);
        chk("valid_low", 32'(inst_valid), 0);
        if (hlt) begin
            for (int i = 0; i < hold; i++) begin
                chk("req_halted", 32'(imem_req), 0);
                chk("pc_halted", pc_cnt, pcr);
                imem_ack = 1'($urandom_range(0, 1));
                if (i == hold - 1) halt = 1'b0;
                @(negedge clk);
            end
            imem_ack = 1'b0;
        end else begin
            chk("req_next", 32'(imem_req), 1);
        end
        cur_pc = pcr;
    endtask

    initial begin
        vecs[0] = '{3, 32'h2008_0005, 32'h0000_0044, 1'b0, 0,
                    32'h0000_0040, 32'h2008_0005};
        vecs[1] = '{0, 32'h0800_0040, 32'h0040_0100, 1'b0, 0,
                    32'h0000_0044, 32'h0800_0040};
        vecs[2] = '{1, 32'h1234_5678, 32'h0040_0104, 1'b1, 3,
                    32'h0040_0100, 32'h1234_5678};
        vecs[3] = '{2, 32'hDEAD_BEEF, 32'hFFFF_FFFC, 1'b0, 0,
                    32'h0040_0104, 32'hDEAD_BEEF};
        vecs[4] = '{0, 32'h0000_0000, 32'h0000_0000, 1'b1, 1,
                    32'hFFFF_FFFC, 32'h0000_0000};
        vecs[5] = '{0, 32'hFFFF_FFFF, 32'h0000_0040, 1'b0, 0,
                    32'h0000_0000, 32'hFFFF_FFFF};

        // Zero-wait memory with ack tied high, including through IDLE.
        do_reset();
        imem_ack = 1'b1;
        @(negedge clk);
        chk("first_req", 32'(imem_req), 1);
        chk("first_addr", imem_addr, RST_PC);
        chk("idle_no_valid", 32'(inst_valid), 0);
        for (int i = 0; i < 3; i++) begin
            fetch_one(0, 32'h1000_0000 + 32'(i), cur_pc + PC_STEP, 1'b0, 0,
                      cur_pc, 32'h1000_0000 + 32'(i));
        end
        chk("retire3", retire_cnt, 3);

        do_reset();
        foreach (vecs[i]) begin
            fetch_one(vecs[i].wait_c, vecs[i].rdata, vecs[i].pcr, vecs[i].hlt,
                      vecs[i].hold, vecs[i].exp_addr, vecs[i].exp_inst);
        end

        for (int i = 0; i < 40; i++) begin
            logic [31:0] rd;
            logic [31:0] pcr;
            logic        h;
            rd  = $urandom();
            pcr = $urandom() & 32'hFFFF_FFFC;
            h   = ($urandom_range(0, 5) == 0);
            fetch_one(int'($urandom_range(0, TMO - 1)), rd, pcr, h,
                      int'($urandom_range(1, 3)), cur_pc, rd);
        end

        // Misaligned branch target.
        do_reset();
        fetch_one(0, 32'h2008_0005, 32'h0000_0044, 1'b0, 0, RST_PC, 32'h2008_0005);
        wait_req();
        imem_ack = 1'b1;
        pc_return = 32'h0000_0046;
        halt = 1'b0;
        @(negedge clk);
        chk("mis_valid", 32'(inst_valid), 1);
        imem_ack = 1'b0;
        exp_retire++;
        @(negedge clk);
        chk("mis_err", 32'(fetch_err), 1);
        chk("mis_code", 32'(err_code), 32'(ERR_ALIGN));
        chk("mis_pc", pc_cnt, 32'h0000_0044);
        chk("mis_retire", retire_cnt, exp_retire);
        for (int i = 0; i < 4; i++) begin
            imem_ack = 1'b1;
            pc_return = $urandom() & 32'hFFFF_FFFC;
            halt = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("err_req", 32'(imem_req), 0);
            chk("err_valid", 32'(inst_valid), 0);
            chk("err_pc", pc_cnt, 32'h0000_0044);
            chk("err_retire", retire_cnt, exp_retire);
        end
        imem_ack = 1'b0;
        halt = 1'b0;

        // Memory never answers.
        do_reset();
        begin
            int req_cycles = 0;
            int n = 0;
            while (!imem_req && n < 10) begin
                @(negedge clk);
                n++;
            end
            while (imem_req && req_cycles < 20) begin
                @(negedge clk);
                req_cycles++;
            end
            chk("tmo_cycles", 32'(req_cycles), TMO);
        end
        chk("tmo_err", 32'(fetch_err), 1);
        chk("tmo_code", 32'(err_code), 32'(ERR_TIMEOUT));
        chk("tmo_pc", pc_cnt, RST_PC);
        repeat (3) @(negedge clk);
        chk("tmo_sticky", 32'(fetch_err), 1);
        chk("tmo_req_low", 32'(imem_req), 0);

        // Reset recovers, then reset again while a fetch is pending.
        do_reset();
        wait_req();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("async_req_drop", 32'(imem_req), 0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
